load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum ACCESS-state cycles to wait for MemAck before aborting.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  one-cycle request pulse from execute stage; sampled only in IDLE.
REQ-005 MemRead  input  1  request is a word load.
REQ-006 MemWrite  input  1  request is a word store.
REQ-007 Address  input  32  byte address of the access.
REQ-008 WriteData  input  32  store data.
REQ-009 Busy  output  1  high while state is not IDLE; pipeline stall.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 ReadData  output  32  registered load result; feeds the write-back data select (Input1).
REQ-012 Err  output  1  registered; valid with Done; misalign, illegal op, or timeout.
REQ-013 MemReq  output  1  memory request, held until ack or abort.
REQ-014 MemWe  output  1  store strobe, valid with MemReq.
REQ-015 MemAddr  output  30  word address (Address[31:2]), registered at accept.
REQ-016 MemWData  output  32  store data, registered at accept.
REQ-017 MemAck  input  1  memory completion, single cycle.
REQ-018 MemRData  input  32  load data, valid with MemAck.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-020 In IDLE, Start=1 with exactly one of MemRead/MemWrite and Address[1:0]=0 SHALL register address, data, and op, then enter ACCESS.
REQ-021 In IDLE, Start=1 with misaligned Address or MemRead=MemWrite=1 SHALL enter DONE with Err=1, no MemReq issued.
REQ-022 In IDLE, Start=1 with MemRead=MemWrite=0 SHALL be ignored (no state change).
REQ-023 Start while not IDLE SHALL be ignored; no queueing.
REQ-024 In ACCESS, MemReq=1, MemWe=registered store op; wait counter increments each cycle.
REQ-025 MemAck=1 in ACCESS SHALL enter DONE with Err=0; on load, ReadData captures MemRData at that same edge.
REQ-026 Counter reaching TIMEOUT-1 without MemAck SHALL enter DONE with Err=1; ReadData unchanged.
REQ-027 MemAck and timeout in the same cycle: the ack wins, Err=0.
REQ-028 MemAck outside ACCESS SHALL be ignored.
REQ-029 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-030 Minimum latency: Start at edge N, ack during cycle N+1, Done high in cycle N+2; Start accepted again at edge N+3.
REQ-031 ReadData SHALL hold its value until the next successful load; stores, errors, and timeouts do not alter it.
REQ-032 Counter width SHALL be clog2(TIMEOUT)+1 bits and SHALL clear on entry to ACCESS.

Reset
REQ-033 Reset=1 at an edge SHALL force IDLE, counter=0, and ReadData, MemAddr, MemWData=0 and Err, Done, MemReq, MemWe=0, overriding all other inputs.
REQ-034 Reset during ACCESS SHALL drop MemReq in the cycle after that edge; a late MemAck SHALL be ignored.

Structure
REQ-035 State encoding and default TIMEOUT SHALL reside in the shared package lsu_pkg.
REQ-036 Wait counter SHALL be a sub-module lsu_timeout_ctr (clear, enable, expire outputs); all else is flat.

Verification
REQ-037 Load: Address=0x0000_0010, MemRead=1, MemAck after 2 ACCESS cycles with MemRData=0xDEAD_BEEF -> MemAddr=0x4, Done once, Err=0, ReadData=0xDEAD_BEEF.
REQ-038 Store: Address=0x20, WriteData=0x1234_5678, immediate ack -> MemWe=1, MemWData=0x1234_5678, Done at N+2, ReadData unchanged.
REQ-039 Misalign: Address=0x13, MemRead=1 -> MemReq never asserted, Done with Err=1 one cycle after accept.
REQ-040 Timeout: TIMEOUT=16, no MemAck -> MemReq high exactly 16 cycles, then Done with Err=1; ReadData keeps prior 0xDEAD_BEEF.
REQ-041 Reset in 3rd ACCESS cycle, MemAck one cycle later -> IDLE, all outputs 0, no Done pulse.
REQ-042 Start re-pulsed during ACCESS with different Address -> ignored; MemAddr unchanged until Done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and default timeout.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Wait counter for the ACCESS state; flags expiry on the last allowed cycle.
module lsu_timeout_ctr #(
    parameter int TIMEOUT = lsu_pkg::LSU_TIMEOUT_DEFAULT,
    parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Count waiting cycles; clear wins so the count starts at zero on ACCESS entry.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding word load/store unit between the execute stage and memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] ReadData,
    output logic        Err,
    output logic        MemReq,
    output logic        MemWe,
    output logic [29:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    lsu_state_t state;

    logic one_op;
    logic aligned;
    logic accept;
    logic reject;
    logic expire;

    // Exactly one of read/write selects a legal op; both set is illegal, neither is a no-op.
    assign one_op  = MemRead ^ MemWrite;
    assign aligned = (Address[1:0] == 2'b00);
    assign accept  = (state == IDLE) && Start && one_op && aligned;
    assign reject  = (state == IDLE) && Start && ((MemRead && MemWrite) || (one_op && !aligned));

    assign Busy = (state != IDLE);

    lsu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (accept),
        .enable (state == ACCESS),
        .expire (expire)
    );

    // Control FSM with registered memory-side and completion outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            Done     <= 1'b0;
            Err      <= 1'b0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            ReadData <= '0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        MemAddr  <= Address[31:2];
                        MemWData <= WriteData;
                        MemWe    <= MemWrite;
                        MemReq   <= 1'b1;
                        state    <= ACCESS;
                    end else if (reject) begin
                        Done  <= 1'b1;
                        Err   <= 1'b1;
                        state <= DONE;
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a coincident timeout.
                    if (MemAck) begin
                        if (!MemWe) begin
                            ReadData <= MemRData;
                        end
                        MemReq <= 1'b0;
                        MemWe  <= 1'b0;
                        Done   <= 1'b1;
                        state  <= DONE;
                    end else if (expire) begin
                        MemReq <= 1'b0;
                        MemWe  <= 1'b0;
                        Done   <= 1'b1;
                        Err    <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a transaction-level model.
module tb_load_store_unit;

    localparam int TB_TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] ReadData;
    logic        Err;
    logic        MemReq;
    logic        MemWe;
    logic [29:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;

    int vectors    = 0;
    int miscompares = 0;

    // Last successfully loaded word, as the unit should report it.
    logic [31:0] model_rdata;

    load_store_unit #(
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .ReadData  (ReadData),
        .Err       (Err),
        .MemReq    (MemReq),
        .MemWe     (MemWe),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemAck    (MemAck),
        .MemRData  (MemRData)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request from the execute stage; ack_at is the ACCESS cycle index (0-based)
    // in which memory acks, values >= TB_TIMEOUT mean memory never answers.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at,
                          input logic [31:0] rdata, input bit repulse);
        int  n_req;
        bit  exp_err;
        Start     = 1'b1;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wdata;
        MemAck    = 1'b0;
        tick();
        Start = 1'b0;
        if (!rd && !wr) begin
            chk("ignore_busy", Busy, 1'b0);
            chk("ignore_done", Done, 1'b0);
            chk("ignore_req", MemReq, 1'b0);
            chk("ignore_rdata", ReadData, model_rdata);
        end else if ((rd && wr) || addr[1:0] != 2'b00) begin
            chk("illegal_done", Done, 1'b1);
            chk("illegal_err", Err, 1'b1);
            chk("illegal_req", MemReq, 1'b0);
            chk("illegal_busy", Busy, 1'b1);
            tick();
            chk("illegal_done_end", Done, 1'b0);
            chk("illegal_busy_end", Busy, 1'b0);
            chk("illegal_req_end", MemReq, 1'b0);
            chk("illegal_rdata", ReadData, model_rdata);
        end else begin
            exp_err = (ack_at >= TB_TIMEOUT);
            n_req   = exp_err ? TB_TIMEOUT : ack_at + 1;
            for (int i = 0; i < n_req; i++) begin
                chk("acc_req", MemReq, 1'b1);
                chk("acc_we", MemWe, wr);
                chk("acc_addr", MemAddr, addr[31:2]);
                if (wr) chk("acc_wdata", MemWData, wdata);
                chk("acc_busy", Busy, 1'b1);
                chk("acc_done", Done, 1'b0);
                chk("acc_rdata", ReadData, model_rdata);
                MemAck   = (i == ack_at);
                MemRData = (i == ack_at) ? rdata : $urandom;
                if (repulse && i == 1) begin
                    Start    = 1'b1;
                    MemRead  = 1'b1;
                    MemWrite = 1'b0;
                    Address  = addr + 32'h100;
                end
                tick();
                MemAck = 1'b0;
                Start  = 1'b0;
            end
            if (rd && !exp_err) model_rdata = rdata;
            chk("end_done", Done, 1'b1);
            chk("end_err", Err, exp_err);
            chk("end_req", MemReq, 1'b0);
            chk("end_addr", MemAddr, addr[31:2]);
            chk("end_rdata", ReadData, model_rdata);
            tick();
            chk("post_done", Done, 1'b0);
            chk("post_busy", Busy, 1'b0);
            chk("post_req", MemReq, 1'b0);
            chk("post_rdata", ReadData, model_rdata);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        Reset     = 1'b1;
        Start     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        MemAck    = 1'b0;
        MemRData  = '0;
        model_rdata = '0;
        tick();
        tick();
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_req", MemReq, 1'b0);
        chk("rst_we", MemWe, 1'b0);
        chk("rst_addr", MemAddr, 30'd0);
        chk("rst_wdata", MemWData, 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        Reset = 1'b0;
        tick();

        // Load with ack in the third ACCESS cycle.
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
        // Store with immediate ack.
        do_txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 0, 32'hAAAA_5555, 1'b0);
        // Misaligned load, both ops, neither op.
        do_txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, 1'b0);
        do_txn(1'b1, 1'b1, 32'h0000_0040, 32'h0, 0, 32'h0, 1'b0);
        do_txn(1'b0, 1'b0, 32'h0000_0044, 32'h0, 0, 32'h0, 1'b0);
        // Timeout keeps previous load data.
        do_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, TB_TIMEOUT + 3, 32'h0, 1'b0);
        // Ack on the last allowed cycle beats the timeout.
        do_txn(1'b1, 1'b0, 32'h0000_0084, 32'h0, TB_TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);
        // Start re-pulsed mid-access is ignored.
        do_txn(1'b0, 1'b1, 32'h0000_0100, 32'h5A5A_A5A5, 4, 32'h0, 1'b1);

        // Stray ack while idle changes nothing.
        MemAck   = 1'b1;
        MemRData = 32'h0BAD_0BAD;
        tick();
        MemAck = 1'b0;
        chk("idle_ack_done", Done, 1'b0);
        chk("idle_ack_rdata", ReadData, model_rdata);

        // Reset in the third ACCESS cycle, ack arriving one cycle later.
        Start    = 1'b1;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        Address  = 32'h0000_0200;
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk("pre_rst_req", MemReq, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_rdata = '0;
        chk("mid_rst_busy", Busy, 1'b0);
        chk("mid_rst_req", MemReq, 1'b0);
        chk("mid_rst_we", MemWe, 1'b0);
        chk("mid_rst_addr", MemAddr, 30'd0);
        chk("mid_rst_rdata", ReadData, 32'd0);
        chk("mid_rst_done", Done, 1'b0);
        MemAck   = 1'b1;
        MemRData = 32'h7777_7777;
        tick();
        MemAck = 1'b0;
        chk("late_ack_done", Done, 1'b0);
        chk("late_ack_busy", Busy, 1'b0);
        chk("late_ack_rdata", ReadData, 32'd0);

        // Randomized mix of requests.
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (kind < 4)
                do_txn(1'b1, 1'b0, a, $urandom, $urandom_range(0, TB_TIMEOUT + 1), $urandom, 1'($urandom_range(0, 1)));
            else if (kind < 8)
                do_txn(1'b0, 1'b1, a, $urandom, $urandom_range(0, TB_TIMEOUT + 1), $urandom, 1'($urandom_range(0, 1)));
            else if (kind == 8)
                do_txn(1'b1, 1'b1, a, $urandom, 0, $urandom, 1'b0);
            else
                do_txn(1'b0, 1'b0, a, $urandom, 0, $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
